// File: rtl/mem_port_arbiter_if.sv
// Host-side request/grant and read-return bundle for mem_port_arbiter.
// The slave modport is the arbiter side; master is the host/loader side.
interface mem_port_arbiter_if #(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                  i_h_req;
    logic                  i_h_we;
    logic [ADDR_WIDTH-1:0] i_h_addr;
    logic [DWIDTH-1:0]     i_h_wdata;
    logic                  o_h_gnt;
    logic [DWIDTH-1:0]     o_h_rdata;
    logic                  o_h_rvalid;

    modport slave (
        input  i_h_req, i_h_we, i_h_addr, i_h_wdata,
        output o_h_gnt, o_h_rdata, o_h_rvalid
    );

    modport master (
        output i_h_req, i_h_we, i_h_addr, i_h_wdata,
        input  o_h_gnt, o_h_rdata, o_h_rvalid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the CPU and a host requester.
// Optional macro ARB_STARVE_GUARD_EN bounds host wait time by preempting the CPU.
module mem_port_arbiter #(
    parameter int DWIDTH       = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_cpu_ce,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DWIDTH-1:0]     i_cpu_data,
    output logic [DWIDTH-1:0]     o_cpu_data,
    output logic                  o_cpu_wait,
    mem_port_arbiter_if.slave     host,
    output logic                  o_mem_ce,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0]     o_mem_data,
    input  logic [DWIDTH-1:0]     i_mem_data
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HRD1,
        S_HRD2
    } state_e;

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              h_rd_pend2;
    logic              starve;
    logic              gnt;

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] cnt_q, cnt_d;

    assign starve = (cnt_q >= 8'(STARVE_LIMIT));

    always_comb begin
        cnt_d = 8'd0;
        if (host.i_h_req && !gnt) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= 8'd0;
        else          cnt_q <= cnt_d;
    end

    assign o_cpu_wait = gnt & i_cpu_ce;
`else
    assign starve     = 1'b0;
    assign o_cpu_wait = 1'b0;
`endif

    // Only the data-arrival cycle blocks; a grant in S_HRD2 pipelines reads.
    assign h_rd_pend2   = (state_q == S_HRD1);
    assign gnt          = host.i_h_req & ~h_rd_pend2 & (~i_cpu_ce | starve);
    assign host.o_h_gnt = gnt;

    always_comb begin
        o_mem_ce   = i_cpu_ce;
        o_mem_we   = i_cpu_we & i_cpu_ce;
        o_mem_addr = i_cpu_addr;
        o_mem_data = i_cpu_data;
        if (gnt) begin
            o_mem_ce   = 1'b1;
            o_mem_we   = host.i_h_we;
            o_mem_addr = host.i_h_addr;
            o_mem_data = host.i_h_wdata;
        end
    end

    assign o_cpu_data = i_mem_data;

    always_comb begin
        state_d  = S_IDLE;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        unique case (state_q)
            S_IDLE, S_HRD2: begin
                if (gnt && !host.i_h_we) state_d = S_HRD1;
            end
            S_HRD1: begin
                state_d  = S_HRD2;
                rdata_d  = i_mem_data;
                rvalid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign host.o_h_rdata  = rdata_q;
    assign host.o_h_rvalid = rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter with a behavioural model.
// Build with +define+ARB_STARVE_GUARD_EN to check the starvation guard.
module tb_mem_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_ce = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_wait;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rd = '0;

    mem_port_arbiter_if #(.DWIDTH(DW), .ADDR_WIDTH(AW)) hif ();

    mem_port_arbiter #(.DWIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_cpu_ce(cpu_ce), .i_cpu_we(cpu_we),
        .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
        .o_cpu_data(cpu_rdata), .o_cpu_wait(cpu_wait),
        .host(hif.slave),
        .o_mem_ce(mem_ce), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_data(mem_wdata),
        .i_mem_data(mem_rd)
    );

    always #5 clk = ~clk;

    // Memory macro driven by the DUT pins
    logic [DW-1:0] mem [4096];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rd <= mem[mem_addr];
        end
    end

    // Behavioural model
    typedef struct { int due; logic [DW-1:0] data; } rd_t;
    logic [DW-1:0] ref_mem [4096];
    rd_t rq[$];
    int  cyc = 0;
    bit  m_blocked = 0;
    int  m_wait = 0;
    bit  in_reset = 1;
    bit  e_gnt;

    int checks = 0;
    int errors = 0;

    // Observed values of the last stepped cycle
    bit            s_gnt, s_rvalid, s_wait;
    logic [DW-1:0] s_rdata;
    logic [AW-1:0] s_addr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        bit starve, e_rv;
        starve = 0;
`ifdef ARB_STARVE_GUARD_EN
        starve = (m_wait >= LIMIT);
`endif
        e_gnt = hif.i_h_req && !m_blocked && (!cpu_ce || starve);
        e_rv = (rq.size() > 0) && (rq[0].due == cyc);
        chk("gnt", 32'(hif.o_h_gnt), 32'(e_gnt));
        chk("mem_ce", 32'(mem_ce), 32'(e_gnt || cpu_ce));
        chk("mem_we", 32'(mem_we),
            32'(e_gnt ? hif.i_h_we : (cpu_we && cpu_ce)));
        chk("mem_addr", 32'(mem_addr), 32'(e_gnt ? hif.i_h_addr : cpu_addr));
        chk("mem_data", 32'(mem_wdata), 32'(e_gnt ? hif.i_h_wdata : cpu_data));
        chk("cpu_wait", 32'(cpu_wait), 32'(e_gnt && cpu_ce));
        chk("cpu_data", 32'(cpu_rdata), 32'(mem_rd));
        chk("rvalid", 32'(hif.o_h_rvalid), 32'(e_rv));
        if (e_rv) chk("rdata", 32'(hif.o_h_rdata), 32'(rq[0].data));
    endtask

    task automatic model_update();
        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        if (e_gnt) begin
            if (hif.i_h_we) ref_mem[hif.i_h_addr] = hif.i_h_wdata;
            else rq.push_back('{due: cyc + 2, data: ref_mem[hif.i_h_addr]});
        end else if (cpu_ce && cpu_we) begin
            ref_mem[cpu_addr] = cpu_data;
        end
        m_blocked = e_gnt && !hif.i_h_we;
        if (hif.i_h_req && !e_gnt) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
        else m_wait = 0;
    endtask

    task automatic step();
        @(negedge clk);
        if (in_reset) begin
            chk("rst_rvalid", 32'(hif.o_h_rvalid), 32'd0);
            chk("rst_rdata", 32'(hif.o_h_rdata), 32'd0);
            chk("rst_wait", 32'(cpu_wait), 32'd0);
            chk("rst_mem_ce", 32'(mem_ce), 32'(cpu_ce));
            chk("rst_mem_addr", 32'(mem_addr), 32'(cpu_addr));
        end else begin
            model_check();
        end
        s_gnt = hif.o_h_gnt;
        s_rvalid = hif.o_h_rvalid;
        s_rdata = hif.o_h_rdata;
        s_wait = cpu_wait;
        s_addr = mem_addr;
        @(posedge clk);
        if (!in_reset) model_update();
        cyc++;
        #1;
    endtask

    task automatic enter_reset();
        reset_n = 1'b0;
        in_reset = 1;
        rq.delete();
        m_blocked = 0;
        m_wait = 0;
        hif.i_h_req = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic idle();
        cpu_ce = 1'b0; cpu_we = 1'b0;
        hif.i_h_req = 1'b0;
    endtask

    task automatic host_set(bit we, int addr, int data);
        hif.i_h_req = 1'b1;
        hif.i_h_we = we;
        hif.i_h_addr = AW'(addr);
        hif.i_h_wdata = DW'(data);
    endtask

    initial begin
        int k, n;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[12'h020] = 16'h1234;
        ref_mem[12'h020] = 16'h1234;
        hif.i_h_req = 1'b0; hif.i_h_we = 1'b0;
        hif.i_h_addr = '0; hif.i_h_wdata = '0;

        // Reset with random CPU inputs (reads only)
        enter_reset();
        for (int i = 0; i < 4; i++) begin
            cpu_ce = (i == 0) ? 1'b0 : 1'($urandom);
            cpu_addr = AW'($urandom);
            cpu_data = DW'($urandom);
            step();
        end
        idle();
        reset_n = 1'b1;
        in_reset = 0;
        step();

        // Host write while CPU idle
        host_set(1, 12'h010, 16'hBEEF);
        step();
        chk("wr_gnt", 32'(s_gnt), 32'd1);
        chk("wr_addr", 32'(s_addr), 32'h010);
        idle();
        step();
        chk("wr_mem", 32'(mem[12'h010]), 32'hBEEF);

        // Single host read of 0x020
        host_set(0, 12'h020, 0);
        step();
        chk("rd_gnt", 32'(s_gnt), 32'd1);
        idle();
        step();
        chk("rd_n1_rvalid", 32'(s_rvalid), 32'd0);
        step();
        chk("rd_n2_rvalid", 32'(s_rvalid), 32'd1);
        chk("rd_n2_rdata", 32'(s_rdata), 32'h1234);
        step();
        chk("rd_n3_rvalid", 32'(s_rvalid), 32'd0);

        // Four queued reads complete in 8 cycles after the first grant
        k = 0; n = 0;
        host_set(0, 12'h020, 0);
        for (int c = 0; c < 9; c++) begin
            step();
            if (s_rvalid) n++;
            if (s_gnt) begin
                k++;
                if (k < 4) host_set(0, 12'h020 + k, 0);
                else hif.i_h_req = 1'b0;
            end
        end
        chk("burst_gnts", 32'(k), 32'd4);
        chk("burst_rvalids", 32'(n), 32'd4);
        idle();
        step(); step();

        // Contention: CPU busy 5 cycles, host granted on the 6th
        host_set(1, 12'h033, 16'h5A5A);
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0AA;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("cont_nogrant", 32'(s_gnt), 32'd0);
            chk("cont_cpu_addr", 32'(s_addr), 32'h0AA);
        end
        cpu_ce = 1'b0;
        step();
        chk("cont_grant6", 32'(s_gnt), 32'd1);
        idle();
        step();

        // Starvation: CPU ce held high constantly
        host_set(1, 12'h044, 16'h7777);
        cpu_ce = 1'b1; cpu_addr = 12'h0BB;
        k = -1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (s_gnt) begin
                k = c;
                chk("starve_wait", 32'(s_wait), 32'd1);
                break;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_cycle", 32'(k), 32'(LIMIT));
`else
        chk("starve_never", 32'(k), 32'hFFFF_FFFF);
`endif
        idle();
        step(); step();

        // Reset during S_HRD1 drops the read
        host_set(0, 12'h020, 0);
        step();
        chk("rr_gnt", 32'(s_gnt), 32'd1);
        idle();
        enter_reset();
        step(); step();
        reset_n = 1'b1;
        in_reset = 0;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (s_rvalid) n++;
        end
        chk("rr_no_rvalid", 32'(n), 32'd0);
        host_set(0, 12'h020, 0);
        step();
        idle();
        step(); step();
        chk("rr_rvalid", 32'(s_rvalid), 32'd1);
        chk("rr_rdata", 32'(s_rdata), 32'h1234);

        // Randomized traffic; host fields held until granted
        for (int c = 0; c < 600; c++) begin
            if (!hif.i_h_req || s_gnt) begin
                hif.i_h_req = ($urandom_range(0, 2) != 0);
                hif.i_h_we = 1'($urandom);
                hif.i_h_addr = AW'($urandom_range(0, 15));
                hif.i_h_wdata = DW'($urandom);
            end
            cpu_ce = ($urandom_range(0, 9) < 7);
            cpu_we = 1'($urandom);
            cpu_addr = AW'($urandom_range(0, 15));
            cpu_data = DW'($urandom);
            step();
        end
        idle();
        for (int c = 0; c < 4; c++) step();
        chk("queue_drained", 32'(rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between the CPU core and a host/loader requester (program load, debug peek/poke, future DMA).
- Sits between the CPU top-level memory pins and the memory macro; CPU keeps strict priority by default.
- Host uses a req/gnt issue handshake with a separate registered read-return; an optional starvation guard bounds host wait time.

Parameters:
- DWIDTH, 16, memory data width
- ADDR_WIDTH, 12, memory address width
- STARVE_LIMIT, 8, host wait cycles before guard fires (used only with ARB_STARVE_GUARD_EN; legal 1..255)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_cpu_ce  in  1  CPU memory access request
- i_cpu_we  in  1  CPU write enable
- i_cpu_addr  in  ADDR_WIDTH  CPU address
- i_cpu_data  in  DWIDTH  CPU write data
- o_cpu_data  out  DWIDTH  CPU read data (i_mem_data passthrough)
- o_cpu_wait  out  1  CPU must hold its access; memory is taken by host
- i_h_req  in  1  host request; fields held stable until o_h_gnt
- i_h_we  in  1  host write enable
- i_h_addr  in  ADDR_WIDTH  host address
- i_h_wdata  in  DWIDTH  host write data
- o_h_gnt  out  1  host access issued to memory this cycle (combinational pulse)
- o_h_rdata  out  DWIDTH  registered host read data
- o_h_rvalid  out  1  one-cycle pulse, o_h_rdata valid
- o_mem_ce / o_mem_we  out  1 / 1  memory enables
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_data  out  DWIDTH  memory write data
- i_mem_data  in  DWIDTH  memory read data, valid the cycle after a read issue

Behaviour:
- Clock and reset: single clock clk; reset_n asynchronous, active low.
- Reset values: state=S_IDLE, o_h_rdata=0, o_h_rvalid=0, wait counter=0, read-pending flags=0, o_cpu_wait=0.
- Memory mux (combinational): if host granted this cycle, drive host fields with o_mem_ce=1; else drive CPU fields with o_mem_ce=i_cpu_ce and o_mem_we=i_cpu_we&i_cpu_ce.
- Grant rule, default:
  - o_h_gnt = i_h_req & ~i_cpu_ce & ~h_rd_pend2, where h_rd_pend2 is the data-capture stage below.
  - Host thus issues at most one access every cycle the CPU is idle.
- FSM states:
  - S_IDLE: no host read outstanding.
  - S_HRD1: host read issued last cycle; memory data arriving.
  - S_HRD2: capture done; o_h_rvalid high.
  - Transitions: S_IDLE -> S_HRD1 on a granted host read. S_HRD1 -> S_HRD2 unconditionally, capturing i_mem_data into o_h_rdata. S_HRD2 -> S_IDLE.
  - A host write grant leaves the state at S_IDLE.
- Host read latency: gnt at cycle N, memory data at N+1, o_h_rvalid/o_h_rdata at N+2.
- New host grants are blocked in S_HRD1 only. A grant in S_HRD2 is allowed, giving back-to-back reads every 2 cycles.
- CPU accesses are never blocked by S_HRD1/S_HRD2; the CPU owns the port whenever it does not lose to a grant.
- CPU read data: o_cpu_data = i_mem_data always. The CPU only samples it after its own access.
- Simultaneous i_cpu_ce and i_h_req: CPU wins, host waits, no gnt.
- Reset mid-read: pending read dropped, no rvalid emitted.
- o_h_gnt never asserts while i_h_req=0.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - 8-bit wait counter increments each cycle i_h_req=1 & ~o_h_gnt, clears on gnt or req deassert, and saturates.
  - When counter >= STARVE_LIMIT, the host is granted even if i_cpu_ce=1, and o_cpu_wait=1 in that cycle. The S_HRD1 block still applies.
  - The memory mux selects the host; the CPU must re-present its access next cycle.
- Undefined: no counter, o_cpu_wait tied 0, strict CPU priority.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> o_h_rvalid=0, o_h_rdata=0, o_cpu_wait=0; mem pins follow CPU with ce=0 when i_cpu_ce=0.
- Host write while CPU idle: i_h_req=1, we=1, addr=0x010, wdata=0xBEEF -> same-cycle o_h_gnt=1, o_mem_ce=1, o_mem_we=1, addr 0x010, data 0xBEEF.
- Host read: memory returns 0x1234 for 0x020 -> gnt at N, o_h_rvalid=1 with o_h_rdata=0x1234 at N+2 only; 4 queued reads complete in 8 cycles.
- Contention: i_cpu_ce=1 for 5 cycles with i_h_req=1 -> no gnt for 5 cycles, memory shows CPU address; gnt on cycle 6.
- Starvation (macro on, STARVE_LIMIT=8): CPU ce held high constantly -> gnt with o_cpu_wait=1 after exactly 8 wait cycles. Macro off: never granted.
- Reset asserted in S_HRD1 -> no o_h_rvalid after release; next read returns correct data.
